wb_sequencer: RTL and testbench

WB_SEQUENCER -- requirements
Module: wb_sequencer

---
 rtl/wb_seq_pkg.sv | 59 +++++
 rtl/wb_timeout_cnt.sv | 31 +++
 rtl/wb_sequencer.sv | 164 ++++++++++++++++
 tb/tb_wb_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_seq_pkg.sv
// Shared encodings for the writeback sequencer: op classes, RegDst and
// write-data select codes, FSM states and the default memory timeout.
package wb_seq_pkg;

  localparam int unsigned DEF_MEM_TIMEOUT = 15;

  localparam logic [2:0] OP_R_TYPE = 3'd0;
  localparam logic [2:0] OP_I_TYPE = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_JAL    = 3'd3;
  localparam logic [2:0] OP_PUSH   = 3'd4;
  localparam logic [2:0] OP_POP    = 3'd5;
  localparam logic [2:0] OP_XCHG   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [2:0] DST_RT = 3'd0;
  localparam logic [2:0] DST_RD = 3'd1;
  localparam logic [2:0] DST_RS = 3'd2;
  localparam logic [2:0] DST_RA = 3'd3;
  localparam logic [2:0] DST_SP = 3'd4;

  // Architectural register numbers selected by the DST_RA / DST_SP codes.
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_SP = 5'd29;

  localparam logic [2:0] SRC_ALU    = 3'd0;
  localparam logic [2:0] SRC_MEM    = 3'd1;
  localparam logic [2:0] SRC_PC4    = 3'd2;
  localparam logic [2:0] SRC_SP_ADJ = 3'd3;
  localparam logic [2:0] SRC_B_REG  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WR1      = 3'd2,
    ST_WR2      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic [4:0] dst_regnum(input logic [2:0] dst, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] rs);
    case (dst)
      DST_RD:  return rd;
      DST_RS:  return rs;
      DST_RA:  return REG_RA;
      DST_SP:  return REG_SP;
      default: return rt;
    endcase
  endfunction

  function automatic logic wb_src_valid(input logic [2:0] src);
    return src <= SRC_B_REG;
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// WAIT_MEM timeout counter; expired_o flags that the count reaches LIMIT
// on the next enabled edge.
module wb_timeout_cnt
  import wb_seq_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_sequencer.sv
// Moore writeback sequencer driving RegDst / write-data select and RF write enable.
// Optional XCHG op (second write rs<-B_REG) enabled by `define WB_SEQ_XCHG_EN.
module wb_sequencer
  import wb_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op_class,
  input  logic       mem_ready,
  input  logic       flush,
  output logic [2:0] reg_dst,
  output logic       reg_write,
  output logic [2:0] wb_src,
  output logic       sp_inc,
  output logic       busy,
  output logic       done,
  output logic       err
);

  function automatic logic op_legal(input logic [2:0] op);
`ifdef WB_SEQ_XCHG_EN
    return op != OP_RSVD;
`else
    return (op != OP_RSVD) && (op != OP_XCHG);
`endif
  endfunction

  function automatic logic two_write(input logic [2:0] op);
`ifdef WB_SEQ_XCHG_EN
    return (op == OP_POP) || (op == OP_XCHG);
`else
    return op == OP_POP;
`endif
  endfunction

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] dst_q, dst_d, src_q, src_d;
  logic       rw_q, rw_d, inc_q, inc_d, busy_q, done_q, err_q, err_d;
  logic       tmo_clear, tmo_en, tmo_expired;

  wb_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = 1'b0;
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d = op_class;
            if (!op_legal(op_class)) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end else if (is_mem_op(op_class)) begin
              state_d   = ST_WAIT_MEM;
              tmo_clear = 1'b1;
            end else begin
              state_d = ST_WR1;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (mem_ready) begin
            state_d = ST_WR1;
          end else begin
            tmo_en = 1'b1;
            if (tmo_expired) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          end
        end
        ST_WR1:  state_d = two_write(op_q) ? ST_WR2 : ST_DONE;
        ST_WR2:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decode from the next state so they register on the same edge as the state.
  always_comb begin
    rw_d  = 1'b0;
    dst_d = DST_RT;
    src_d = SRC_ALU;
    inc_d = 1'b0;
    if (state_d == ST_WR1) begin
      rw_d = 1'b1;
      case (op_d)
        OP_R_TYPE:        dst_d = DST_RD;
        OP_LOAD, OP_POP:  src_d = SRC_MEM;
        OP_JAL:           begin dst_d = DST_RA; src_d = SRC_PC4;    end
        OP_PUSH:          begin dst_d = DST_SP; src_d = SRC_SP_ADJ; end
        OP_I_TYPE, OP_XCHG: ;
        default: ;
      endcase
    end else if (state_d == ST_WR2) begin
      case (op_d)
        OP_POP: begin
          rw_d  = 1'b1;
          dst_d = DST_SP;
          src_d = SRC_SP_ADJ;
          inc_d = 1'b1;
        end
`ifdef WB_SEQ_XCHG_EN
        OP_XCHG: begin
          rw_d  = 1'b1;
          dst_d = DST_RS;
          src_d = SRC_B_REG;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      rw_q    <= 1'b0;
      inc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      rw_q    <= rw_d;
      inc_q   <= inc_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= err_d;
    end
  end

  assign reg_dst   = dst_q;
  assign wb_src    = src_q;
  assign reg_write = rw_q;
  assign sp_inc    = inc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed vector table, hand-written
// corner sequences and randomized transactions against a phase-level model.
module tb_wb_sequencer;

  localparam int T = 15;
`ifdef WB_SEQ_XCHG_EN
  localparam bit XEN = 1'b1;
`else
  localparam bit XEN = 1'b0;
`endif

  logic       clk, reset_n, start, mem_ready, flush;
  logic [2:0] op_class, reg_dst, wb_src;
  logic       reg_write, sp_inc, busy, done, err;
  logic [10:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  wb_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op_class  (op_class),
    .mem_ready (mem_ready),
    .flush     (flush),
    .reg_dst   (reg_dst),
    .reg_write (reg_write),
    .wb_src    (wb_src),
    .sp_inc    (sp_inc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {reg_dst, reg_write, wb_src, sp_inc, busy, done, err};

  // Expected output vector: {reg_dst, reg_write, wb_src, sp_inc, busy, done, err}.
  function automatic logic [10:0] E(int dst, int rw, int src, int inc, int b, int d, int e);
    return {dst[2:0], rw[0], src[2:0], inc[0], b[0], d[0], e[0]};
  endfunction

  localparam logic [10:0] Z = 11'd0;
  localparam logic [10:0] B = 11'b000_0_000_0_100;
  localparam logic [10:0] DN = 11'b000_0_000_0_110;
  localparam logic [10:0] DE = 11'b000_0_000_0_111;

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b ({dst,rw,src,inc,busy,done,err}) t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input int op, input bit rdy, input bit fl);
    start = st; op_class = op[2:0]; mem_ready = rdy; flush = fl;
  endtask

  typedef struct {
    bit          st;
    int          op;
    bit          rdy;
    bit          fl;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input bit st, input int op, input bit rdy, input bit fl, input logic [10:0] exp);
    vec_t v;
    v.st = st; v.op = op; v.rdy = rdy; v.fl = fl; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Reference trace: wait phase, then the op's write list, then done.
  logic [10:0] exp_q[$];

  task automatic model(input int op, input int r, output int w);
    bit timed;
    exp_q.delete();
    w = 0;
    timed = 0;
    if (op == 7 || (op == 6 && !XEN)) begin
      exp_q.push_back(DE);
      return;
    end
    if (op == 2 || op == 5) begin
      if (r <= T) w = r;
      else begin w = T; timed = 1; end
    end
    repeat (w) exp_q.push_back(B);
    if (timed) begin
      exp_q.push_back(DE);
      return;
    end
    case (op)
      0: exp_q.push_back(E(1, 1, 0, 0, 1, 0, 0));
      1: exp_q.push_back(E(0, 1, 0, 0, 1, 0, 0));
      2: exp_q.push_back(E(0, 1, 1, 0, 1, 0, 0));
      3: exp_q.push_back(E(3, 1, 2, 0, 1, 0, 0));
      4: exp_q.push_back(E(4, 1, 3, 0, 1, 0, 0));
      5: begin
        exp_q.push_back(E(0, 1, 1, 0, 1, 0, 0));
        exp_q.push_back(E(4, 1, 3, 1, 1, 0, 0));
      end
      default: begin
        exp_q.push_back(E(0, 1, 0, 0, 1, 0, 0));
        exp_q.push_back(E(2, 1, 4, 0, 1, 0, 0));
      end
    endcase
    exp_q.push_back(DN);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, r, op, fc;
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs, Z);
    reset_n = 1'b1;
    step();
    chk("idle_after_reset", obs, Z);

    // Directed table: each row's inputs are sampled at the next edge.
    row(1, 0, 0, 0, E(1, 1, 0, 0, 1, 0, 0));  row(0, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 1, 0, 0, E(0, 1, 0, 0, 1, 0, 0));  row(0, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 3, 0, 0, E(3, 1, 2, 0, 1, 0, 0));  row(0, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 4, 0, 0, E(4, 1, 3, 0, 1, 0, 0));  row(0, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 7, 0, 0, DE);                      row(0, 0, 0, 0, Z);
    if (XEN) begin
      row(1, 6, 0, 0, E(0, 1, 0, 0, 1, 0, 0)); row(0, 0, 0, 0, E(2, 1, 4, 0, 1, 0, 0));
      row(0, 0, 0, 0, DN);                     row(0, 0, 0, 0, Z);
    end else begin
      row(1, 6, 0, 0, DE);                     row(0, 0, 0, 0, Z);
    end
    row(1, 5, 0, 0, B);  row(0, 0, 0, 0, B);  row(0, 0, 0, 0, B);
    row(0, 0, 1, 0, E(0, 1, 1, 0, 1, 0, 0));
    row(0, 0, 1, 0, E(4, 1, 3, 1, 1, 0, 0));
    row(1, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 2, 0, 0, B);  row(0, 0, 1, 0, E(0, 1, 1, 0, 1, 0, 0));  row(0, 0, 0, 0, DN);  row(0, 0, 0, 0, Z);
    row(1, 0, 0, 1, Z);  row(0, 0, 1, 0, Z);
    row(1, 2, 0, 0, B);  row(1, 0, 1, 1, Z);  row(0, 0, 0, 0, Z);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].op, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("tbl[%0d]", i), obs, tbl[i].exp);
    end

    // LOAD with mem_ready never asserted: err+done at cycle T+1, no write.
    drive(1, 2, 0, 0);
    for (int c = 1; c <= T + 2; c++) begin
      step();
      drive(0, 0, 0, 0);
      chk($sformatf("timeout_c%0d", c), obs, (c <= T) ? B : (c == T + 1) ? DE : Z);
    end

    // Flush during WR1 of a two-write op: no WR2, no done, idle next cycle.
    if (XEN) begin
      drive(1, 6, 0, 0); step(); chk("flush_wr1_xchg", obs, E(0, 1, 0, 0, 1, 0, 0));
    end else begin
      drive(1, 5, 0, 0); step(); chk("flush_wr1_pop_wait", obs, B);
      drive(0, 0, 1, 0); step(); chk("flush_wr1_pop", obs, E(0, 1, 1, 0, 1, 0, 0));
    end
    drive(1, 0, 0, 1); step(); chk("flush_to_idle", obs, Z);
    drive(0, 0, 0, 0); step(); chk("flush_no_wr2", obs, Z);
    step(); chk("flush_no_done", obs, Z);

    // start while busy is dropped, not queued.
    drive(1, 4, 0, 0); step(); chk("busy_push_wr1", obs, E(4, 1, 3, 0, 1, 0, 0));
    drive(1, 3, 0, 0); step(); chk("busy_start_ign", obs, DN);
    drive(0, 0, 0, 0); step(); chk("busy_no_queue", obs, Z);

    // Asynchronous reset in WAIT_MEM, then a stray mem_ready.
    drive(1, 2, 0, 0); step(); chk("rst_wait1", obs, B);
    drive(0, 0, 0, 0); step(); chk("rst_wait2", obs, B);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", obs, Z);
    step(); chk("rst_held", obs, Z);
    reset_n = 1'b1;
    drive(0, 0, 1, 0); step(); chk("rst_rdy_ign1", obs, Z);
    step(); chk("rst_rdy_ign2", obs, Z);
    drive(0, 0, 0, 0);

    // Randomized transactions with noise on start/mem_ready and occasional flush.
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 7);
      r  = $urandom_range(1, T + 2);
      model(op, r, w);
      fc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_q.size()) : 0;
      drive(1, op, 0, 0);
      for (int c = 1; c <= exp_q.size(); c++) begin
        step();
        chk($sformatf("rnd%0d_op%0d_c%0d", n, op, c), obs, exp_q[c-1]);
        drive($urandom_range(0, 1), $urandom_range(0, 7),
              (c <= w) ? (c == r) : 1'($urandom_range(0, 1)), (c == fc));
        if (c == fc) begin
          step();
          chk($sformatf("rnd%0d_flush_c%0d", n, c), obs, Z);
          break;
        end
      end
      drive(0, 0, 0, 0);
      step();
      chk($sformatf("rnd%0d_idle", n), obs, Z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
